// File: rtl/b2g_arbiter.sv
// Round-robin arbiter feeding a shared registered binary-to-Gray converter.
// Optional macro B2G_ARB_PARITY_EN adds the registered out_parity output.
module b2g_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bin_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      gray_out,
  output logic [IDW-1:0]        out_id
`ifdef B2G_ARB_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] k);
    return (k == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (k + IDW'(1'b1));
  endfunction

`ifdef B2G_ARB_PARITY_EN
  function automatic logic word_parity(input logic [WIDTH-1:0] b);
    return ^b;
  endfunction
`endif

  logic [IDW-1:0]   ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] gray_r;
  logic [IDW-1:0]   id_r;
  logic             accept_s;
  logic [IDW-1:0]   grant_idx_s;
  logic [NREQ-1:0]  gnt_s;
  logic [WIDTH-1:0] sel_word_s;
`ifdef B2G_ARB_PARITY_EN
  logic             parity_r;
`endif

  // No grant while reset is held, and none while a word is stuck under backpressure.
  assign accept_s = rst_n && (|req) && (!out_valid_r || out_ready);

  // Round-robin search: scan from the highest offset down so the lowest offset wins.
  always_comb begin
    logic [IDW:0] sum_v;
    logic [IDW:0] idx_v;
    grant_idx_s = {IDW{1'b0}};
    sum_v       = {(IDW+1){1'b0}};
    idx_v       = {(IDW+1){1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum_v       = {1'b0, ptr_r} + (IDW+1)'(i);
      idx_v       = (sum_v >= (IDW+1)'(NREQ)) ? (sum_v - (IDW+1)'(NREQ)) : sum_v;
      grant_idx_s = req[idx_v[IDW-1:0]] ? idx_v[IDW-1:0] : grant_idx_s;
    end
  end

  // One-hot grant, forced to zero whenever nothing is accepted.
  always_comb begin
    gnt_s = {NREQ{1'b0}};
    if (accept_s) begin
      gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      gnt_s = {NREQ{1'b0}};
    end
  end

  // AND-OR mux keyed by the grant so idle lanes (possibly X) never reach the output.
  always_comb begin
    sel_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_word_s = sel_word_s | (bin_in[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
    end
  end

  // Output register, valid flag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= {IDW{1'b0}};
      out_valid_r <= 1'b0;
      gray_r      <= {WIDTH{1'b0}};
      id_r        <= {IDW{1'b0}};
`ifdef B2G_ARB_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else if (accept_s) begin
      ptr_r       <= ptr_after(grant_idx_s);
      out_valid_r <= 1'b1;
      gray_r      <= bin2gray(sel_word_s);
      id_r        <= grant_idx_s;
`ifdef B2G_ARB_PARITY_EN
      parity_r    <= word_parity(sel_word_s);
`endif
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign gnt       = gnt_s;
  assign out_valid = out_valid_r;
  assign gray_out  = gray_r;
  assign out_id    = id_r;
`ifdef B2G_ARB_PARITY_EN
  assign out_parity = parity_r;
`endif

endmodule

// File: tb/tb_b2g_arbiter.sv
// Self-checking bench for b2g_arbiter (WIDTH=4, NREQ=4) against a queue-free
// behavioural model of the round-robin and Gray-conversion rules.
module tb_b2g_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] bin_in;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  gray_out;
  logic [1:0]  out_id;
`ifdef B2G_ARB_PARITY_EN
  logic        out_parity;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_ptr;
  bit         m_valid;
  logic [3:0] m_gray;
  int         m_id;
  bit         m_par;
  bit         m_acc;
  int         m_k;
  logic [3:0] exp_gnt;

  b2g_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .gray_out(gray_out),
    .out_id(out_id)
`ifdef B2G_ARB_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (((r >> ((p + off) % 4)) & 4'd1) != 4'd0) return (p + off) % 4;
    end
    return -1;
  endfunction

  function automatic logic [15:0] lanes(input logic [3:0] r);
    logic [15:0] w;
    w = 16'($urandom);
    for (int i = 0; i < 4; i++) if (!r[i]) w[i*4 +: 4] = 4'bxxxx;
    return w;
  endfunction

  task automatic drive(input logic [3:0] r, input logic [15:0] w, input logic rdy);
    @(negedge clk);
    req = r; bin_in = w; out_ready = rdy;
    m_k = pick(r, m_ptr);
    m_acc = (r != 4'd0) && (!m_valid || rdy);
    exp_gnt = m_acc ? (4'b0001 << m_k) : 4'b0000;
    #1;
  endtask

  task automatic tick;
    logic [3:0] b;
    @(posedge clk);
    if (m_acc) begin
      b = bin_in[m_k*4 +: 4];
      m_gray = b ^ (b >> 1); m_par = ^b; m_id = m_k; m_valid = 1'b1;
      m_ptr = (m_k + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset;
    m_ptr = 0; m_valid = 1'b0; m_gray = 4'd0; m_id = 0; m_par = 1'b0; m_acc = 1'b0;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst_n = 1'b0; req = 4'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req = 4'd0; bin_in = 16'd0; out_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (gray_out !== 4'd0) begin errors++; $display("FAIL rst_gray: got %b want 0000", gray_out); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", out_id); end
    req = 4'b1111; out_ready = 1'b1; #1;
    checks++; if (gnt !== 4'd0) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
    @(negedge clk); req = 4'd0; rst_n = 1'b1;
  endtask

  task automatic test_single;
    drive(4'b0001, {12'hxxx, 4'b1011}, 1'b1);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick();
    checks++; if (gray_out !== 4'b1110) begin errors++; $display("FAIL single_gray: got %b want 1110", gray_out); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", out_id); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    drive(4'b0000, 16'hxxxx, 1'b1);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_rotation;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, lanes(4'b1111), 1'b1);
      checks++; if (gnt !== (4'b0001 << i)) begin errors++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, 4'b0001 << i); end
      tick();
      checks++; if (out_id !== 2'(i)) begin errors++; $display("FAIL rot_id[%0d]: got %0d want %0d", i, out_id, i); end
      checks++; if (gray_out !== m_gray) begin errors++; $display("FAIL rot_gray[%0d]: got %b want %b", i, gray_out, m_gray); end
    end
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
  endtask

  task automatic test_backpressure;
    reset_dut();
    drive(4'b0001, {12'hxxx, 4'b0110}, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, lanes(4'b0100), 1'b0);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt[%0d]: got %b want 0000", i, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1 || gray_out !== 4'b0101 || out_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b g=%b id=%0d want v=1 g=0101 id=0", i, out_valid, gray_out, out_id);
      end
    end
    drive(4'b0100, lanes(4'b0100), 1'b1);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_release_gnt: got %b want 0100", gnt); end
    tick();
    checks++; if (out_id !== 2'd2 || gray_out !== m_gray || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_out: got id=%0d g=%b v=%b want id=2 g=%b v=1", out_id, gray_out, out_valid, m_gray);
    end
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
  endtask

  task automatic test_wrap;
    reset_dut();
    drive(4'b1000, lanes(4'b1000), 1'b1);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_first_gnt: got %b want 1000", gnt); end
    tick();
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
    drive(4'b1001, lanes(4'b1001), 1'b1);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
    tick();
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL wrap_id: got %0d want 0", out_id); end
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
  endtask

  task automatic test_async_reset;
    reset_dut();
    drive(4'b0010, {8'hxx, 4'b1111, 4'hx}, 1'b1); tick();
    drive(4'b0010, {8'hxx, 4'b0011, 4'hx}, 1'b0);
    checks++; if (out_valid !== 1'b1 || gray_out !== 4'b1000 || out_id !== 2'd1) begin
      errors++; $display("FAIL ar_held: got v=%b g=%b id=%0d want v=1 g=1000 id=1", out_valid, gray_out, out_id);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || gray_out !== 4'd0 || out_id !== 2'd0) begin
      errors++; $display("FAIL ar_cleared: got v=%b g=%b id=%0d want v=0 g=0000 id=0", out_valid, gray_out, out_id);
    end
    checks++; if (gnt !== 4'd0) begin errors++; $display("FAIL ar_gnt_in_reset: got %b want 0000", gnt); end
    req = 4'd0; model_reset();
    #1 rst_n = 1'b1;
    drive(4'b0110, lanes(4'b0110), 1'b1);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ar_after_gnt: got %b want 0010", gnt); end
    tick();
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
  endtask

  task automatic test_sweep;
    logic [3:0] v;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      drive(4'b0100, {4'hx, v, 8'hxx}, 1'b1);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sweep_gnt[%0d]: got %b want 0100", i, gnt); end
      tick();
      checks++; if (gray_out !== 4'(i ^ (i >> 1)) || out_id !== 2'd2) begin
        errors++; $display("FAIL sweep_gray[%0d]: got g=%b id=%0d want g=%b id=2", i, gray_out, out_id, 4'(i ^ (i >> 1)));
      end
`ifdef B2G_ARB_PARITY_EN
      checks++; if (out_parity !== 1'($countones(v) % 2)) begin
        errors++; $display("FAIL sweep_parity[%0d]: got %b want %0d", i, out_parity, $countones(v) % 2);
      end
      if (i == 7) begin
        checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL parity_0111: got %b want 1", out_parity); end
      end
`endif
    end
    drive(4'b0000, 16'hxxxx, 1'b1); tick();
  endtask

  task automatic test_random;
    logic [3:0] r;
    logic       rdy;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      r   = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, lanes(r), rdy);
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, gnt, exp_gnt); end
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (gray_out !== m_gray || out_id !== 2'(m_id)) begin
          errors++; $display("FAIL rand_out[%0d]: got g=%b id=%0d want g=%b id=%0d", i, gray_out, out_id, m_gray, m_id);
        end
`ifdef B2G_ARB_PARITY_EN
        checks++; if (out_parity !== m_par) begin errors++; $display("FAIL rand_parity[%0d]: got %b want %b", i, out_parity, m_par); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
